register_bank: RTL
==================

# register_bank

Parametrised bank of NUM_REGS independent NUM_BITS-wide registers. It succeeds the single fixed register used for RNG seeds and configuration, and adds:
- an addressed write port with per-bit mask;
- a registered read port;
- a flat view of all registers;
- optional shadow/commit staging, so multi-word seeds load into the generators atomically.

It sits between the host/config interface and the RNG cores, which consume `all_data`.

## Interface
Parameters:
- NUM_BITS, 8, width of each register (≥1)
- NUM_REGS, 4, number of registers (≥1)
- RST_VAL, {NUM_REGS*NUM_BITS{1'b0}}, flat reset vector; register i resets to RST_VAL[i*NUM_BITS +: NUM_BITS]
- ADDR_BITS (localparam), max(1, $clog2(NUM_REGS)), address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request, sampled each cycle
- wr_addr  in  ADDR_BITS  target register index
- wr_data  in  NUM_BITS  write data
- wr_mask  in  NUM_BITS  per-bit write enable; 1 = update the bit, 0 = keep it
- wr_err  out  1  one-cycle pulse: previous-cycle write had wr_addr ≥ NUM_REGS
- commit  in  1  copy staged values to active registers (shadow build only)
- rd_addr  in  ADDR_BITS  read index
- rd_data  out  NUM_BITS  registered read of the active register at rd_addr
- all_data  out  NUM_REGS*NUM_BITS  combinational view of all active registers; register i at [i*NUM_BITS +: NUM_BITS]
- pending  out  NUM_REGS  per-register flag: staged value not yet committed

## Operation
- Active register i holds the value driven on all_data.
- Masked write: new = (old & ~wr_mask) | (wr_data & wr_mask).
- Invalid write address (wr_addr ≥ NUM_REGS):
  - the write is dropped; no state changes;
  - wr_err = 1 on the next cycle only.
- rd_data reads active storage, never shadow.
  - rd_addr ≥ NUM_REGS returns all zeros.
- Reset (rst_n = 0 at an edge) overrides every other input. After the edge:
  - active registers = RST_VAL; shadow registers = RST_VAL;
  - pending = 0; rd_data = 0; wr_err = 0;
  - a write or commit presented in the same cycle is discarded.
- Shadow behaviour: see Configuration.

## Timing
- Write to active register (non-shadow build): visible on all_data one cycle after the write edge.
- rd_data: one-cycle latency from rd_addr. rd_data reflects the active contents present at the sampling edge; a same-cycle write to the same address is not visible (read-before-write).
- wr_err: asserted exactly one cycle after the offending write.
- Commit (shadow build): all pending registers update together at the commit edge. The active set never shows a partial mix of old and new values.
- Write and commit in the same cycle: the write is merged into the shadow first, then committed. The new value reaches the active register at that same edge, and pending for that register ends 0.
- Repeated writes before a commit: the last masked write wins. Masks accumulate on the shadow copy.
- Commit with pending = 0: no change to any register.

## Configuration
- REGISTER_BANK_SHADOW_EN defined:
  - each register has a shadow copy; writes update the shadow;
  - pending[i] is set on a valid write to register i;
  - commit copies every pending shadow to active and clears all pending bits;
  - the masked merge uses the current shadow value as `old`.
- REGISTER_BANK_SHADOW_EN undefined:
  - no shadow storage;
  - writes update active registers directly, one-cycle latency;
  - commit is ignored; pending is tied to 0.

## Test plan
- Reset: NUM_BITS=8, NUM_REGS=4, RST_VAL=32'hA5A5_1234; hold rst_n=0 for 2 cycles → all_data=32'hA5A5_1234, rd_data=0, pending=0, wr_err=0.
- Masked write, non-shadow build: reg2 = 8'hFF; write wr_data=8'h00, wr_mask=8'h0F → reg2=8'hF0 on the next cycle. rd_addr=2 → rd_data=8'hF0 one cycle later.
- Atomic commit, shadow build:
  - write reg0=8'h11 and reg3=8'h33 → all_data unchanged, pending=4'b1001;
  - commit → both registers update on the same edge, pending=0.
- Simultaneous write + commit, shadow build: reg1 write 8'h77 with commit=1 → reg1=8'h77 after that edge, pending[1]=0.
- Invalid address: NUM_REGS=3, write wr_addr=3 → no register changes; wr_err high for exactly one cycle. rd_addr=3 → rd_data=0.
- Reset mid-operation, shadow build: pending=4'b0110, then assert rst_n=0 together with commit=1 → active registers = RST_VAL, pending=0, staged values lost.

Source files
------------

// File: rtl/register_bank.sv
// Bank of NUM_REGS masked-write registers with registered read and flat view.
// Define REGISTER_BANK_SHADOW_EN to stage writes in shadow copies until commit.

module register_bank_cell #(
  parameter int                 NUM_BITS = 8,
  parameter logic [NUM_BITS-1:0] RST     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_sel,
  input  logic [NUM_BITS-1:0] wr_data,
  input  logic [NUM_BITS-1:0] wr_mask,
  input  logic                commit,
  output logic [NUM_BITS-1:0] q,
  output logic                pending
);
`ifdef REGISTER_BANK_SHADOW_EN
  logic [NUM_BITS-1:0] shadow, staged;
  logic                pend;

  // Shadow equals active whenever pend is clear, so merging into shadow is always correct.
  assign staged  = wr_sel ? ((shadow & ~wr_mask) | (wr_data & wr_mask)) : shadow;
  assign pending = pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q      <= RST;
      shadow <= RST;
      pend   <= 1'b0;
    end else begin
      shadow <= staged;
      if (commit) begin
        pend <= 1'b0;
        if (pend || wr_sel) q <= staged;
      end else if (wr_sel) begin
        pend <= 1'b1;
      end
    end
  end
`else
  logic commit_unused;
  assign commit_unused = commit;
  assign pending       = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n)      q <= RST;
    else if (wr_sel) q <= (q & ~wr_mask) | (wr_data & wr_mask);
  end
`endif
endmodule

module register_bank #(
  parameter int                           NUM_BITS  = 8,
  parameter int                           NUM_REGS  = 4,
  parameter logic [NUM_REGS*NUM_BITS-1:0] RST_VAL   = '0,
  localparam int                          ADDR_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ADDR_BITS-1:0]         wr_addr,
  input  logic [NUM_BITS-1:0]          wr_data,
  input  logic [NUM_BITS-1:0]          wr_mask,
  output logic                         wr_err,
  input  logic                         commit,
  input  logic [ADDR_BITS-1:0]         rd_addr,
  output logic [NUM_BITS-1:0]          rd_data,
  output logic [NUM_REGS*NUM_BITS-1:0] all_data,
  output logic [NUM_REGS-1:0]          pending
);
  localparam logic [ADDR_BITS:0] NREGS = (ADDR_BITS+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][NUM_BITS-1:0] regs;
  logic [NUM_REGS-1:0]               wr_sel;
  logic                              wr_ok, rd_ok;

  // Extra top bit lets a non-power-of-two count be compared without wrapping.
  assign wr_ok    = ({1'b0, wr_addr} < NREGS);
  assign rd_ok    = ({1'b0, rd_addr} < NREGS);
  assign all_data = regs;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign wr_sel[g] = wr_en && wr_ok && (wr_addr == ADDR_BITS'(g));

    register_bank_cell #(
      .NUM_BITS (NUM_BITS),
      .RST      (RST_VAL[g*NUM_BITS +: NUM_BITS])
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_sel  (wr_sel[g]),
      .wr_data (wr_data),
      .wr_mask (wr_mask),
      .commit  (commit),
      .q       (regs[g]),
      .pending (pending[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      rd_data <= rd_ok ? regs[rd_addr] : '0;
      wr_err  <= wr_en && !wr_ok;
    end
  end
endmodule
